// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cpu_pkg: shared fetch-stage types and constants.   rev 1.0      |
// +-----------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_REQ     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DISCARD = 3'd3,
    ST_FAULT   = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_if: fetch-to-decode instruction bundle.      rev 1.0      |
// +-----------------------------------------------------------------+
interface fetch_if;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  modport fu (output instr, output instr_pc, output instr_valid);
  modport cu (input instr, input instr_pc, input instr_valid);
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_unit: PC, imem req/ack fetch, hold, redirect. rev 1.0     |
// +-----------------------------------------------------------------+
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  fetch_state_t r_state, w_state_n;
  logic [31:0]  r_pc, w_pc_n;
  logic [31:0]  r_addr, w_addr_n;
  logic         r_req, w_req_n;
  logic [31:0]  r_instr, w_instr_n;
  logic [31:0]  r_instr_pc, w_instr_pc_n;
  logic         r_valid, w_valid_n;
  logic         r_fault, w_fault_n;
  logic         r_pend_fault, w_pend_fault_n;

  logic w_ack;
  logic w_aligned;
  logic w_outstanding;

  assign w_ack         = r_req & imem_ack;
  assign w_aligned     = (redirect_pc[1:0] == 2'b00);
  // A request that is not completing this cycle cannot be withdrawn.
  assign w_outstanding = ((r_state == ST_REQ) || (r_state == ST_DISCARD)) && !imem_ack;

  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_addr_n       = r_addr;
    w_req_n        = r_req;
    w_instr_n      = r_instr;
    w_instr_pc_n   = r_instr_pc;
    w_valid_n      = r_valid;
    w_fault_n      = r_fault;
    w_pend_fault_n = r_pend_fault;

    if (r_state == ST_RESET) begin
      w_state_n = ST_REQ;
      w_req_n   = 1'b1;
      w_addr_n  = r_pc;
    end else if (redirect_en) begin
      w_valid_n = 1'b0;
      if (w_aligned) begin
        w_pc_n         = redirect_pc;
        w_fault_n      = 1'b0;
        w_pend_fault_n = 1'b0;
        if (w_outstanding) begin
          w_state_n = ST_DISCARD;
        end else begin
          w_state_n = ST_REQ;
          w_req_n   = 1'b1;
          w_addr_n  = redirect_pc;
        end
      end else begin
        w_fault_n = 1'b1;
        if (w_outstanding) begin
          w_state_n      = ST_DISCARD;
          w_pend_fault_n = 1'b1;
        end else begin
          w_state_n      = ST_FAULT;
          w_req_n        = 1'b0;
          w_pend_fault_n = 1'b0;
        end
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_ack) begin
            w_instr_n    = imem_rdata;
            w_instr_pc_n = r_pc;
            w_valid_n    = 1'b1;
            w_req_n      = 1'b0;
            w_state_n    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (advance) begin
            w_pc_n    = r_pc + PC_STEP;
            w_addr_n  = r_pc + PC_STEP;
            w_req_n   = 1'b1;
            w_valid_n = 1'b0;
            w_state_n = ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (w_ack) begin
            if (r_pend_fault) begin
              w_state_n      = ST_FAULT;
              w_req_n        = 1'b0;
              w_pend_fault_n = 1'b0;
            end else begin
              w_state_n = ST_REQ;
              w_req_n   = 1'b1;
              w_addr_n  = r_pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RESET;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_req        <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_instr_pc   <= RESET_PC;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
      r_pend_fault <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_addr       <= w_addr_n;
      r_req        <= w_req_n;
      r_instr      <= w_instr_n;
      r_instr_pc   <= w_instr_pc_n;
      r_valid      <= w_valid_n;
      r_fault      <= w_fault_n;
      r_pend_fault <= w_pend_fault_n;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign fetch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_fetch_unit: directed bench for fetch_unit.      rev 1.0      |
// +-----------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] c_KEY = 32'h1357_0000;
  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        advance;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int n_chk;
  int n_pass;

  // Memory returns address-tagged data so each word is identifiable.
  assign imem_rdata = imem_addr ^ c_KEY;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .advance    (advance),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_hold(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".pc"}, instr_pc, pc);
    chk({tag, ".instr"}, instr, pc ^ c_KEY);
    chk({tag, ".req"}, {31'd0, imem_req}, 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, ".addr"}, imem_addr, 32'h0);
    chk({tag, ".instr"}, instr, c_NOP);
    chk({tag, ".ipc"}, instr_pc, 32'h0);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, ".fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; imem_ack = 1'b0; advance = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk_reset("rst");

    rst = 1'b0;
    step();
    chk_req("start", 1'b1, 32'h0);

    // Zero-wait memory: REQ/HOLD alternation through 0x0, 0x4, 0x8.
    imem_ack = 1'b1;
    step(); chk_hold("h0", 32'h0);
    advance = 1'b1;
    step(); chk_req("r4", 1'b1, 32'h4);
    chk("r4.valid", {31'd0, instr_valid}, 32'd0);
    advance = 1'b0;
    step(); chk_hold("h4", 32'h4);
    advance = 1'b1;
    step(); chk_req("r8", 1'b1, 32'h8);
    advance = 1'b0;
    step(); chk_hold("h8", 32'h8);

    // Redirect beats advance in HOLD.
    redirect_en = 1'b1; redirect_pc = 32'h100; advance = 1'b1;
    step(); chk_req("rd100", 1'b1, 32'h100);
    chk("rd100.valid", {31'd0, instr_valid}, 32'd0);
    redirect_en = 1'b0; advance = 1'b0; imem_ack = 1'b0;

    // Three wait states: address stable, valid only after ack.
    for (int i = 0; i < 3; i++) begin
      step(); chk_req("ws", 1'b1, 32'h100);
      chk("ws.valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    step(); chk_hold("h100", 32'h100);
    imem_ack = 1'b0;

    // Redirect during an outstanding request: old word dropped.
    advance = 1'b1;
    step(); chk_req("r104", 1'b1, 32'h104);
    advance = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    step(); chk_req("dis", 1'b1, 32'h104);
    chk("dis.valid", {31'd0, instr_valid}, 32'd0);
    redirect_en = 1'b0;
    step(); chk_req("dis2", 1'b1, 32'h104);
    imem_ack = 1'b1;
    step(); chk_req("r200", 1'b1, 32'h200);
    chk("r200.valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h250;
    step(); chk_req("dis3", 1'b1, 32'h200);
    redirect_pc = 32'h300;
    step(); chk_req("dis4", 1'b1, 32'h200);
    redirect_en = 1'b0; imem_ack = 1'b1;
    step(); chk_req("r300", 1'b1, 32'h300);
    step(); chk_hold("h300", 32'h300);

    // Misaligned redirect from HOLD, then aligned recovery.
    redirect_en = 1'b1; redirect_pc = 32'h102;
    step();
    chk("flt.fault", {31'd0, fetch_fault}, 32'd1);
    chk("flt.valid", {31'd0, instr_valid}, 32'd0);
    chk("flt.req", {31'd0, imem_req}, 32'd0);
    redirect_en = 1'b0;
    step();
    chk("flt2.fault", {31'd0, fetch_fault}, 32'd1);
    chk("flt2.req", {31'd0, imem_req}, 32'd0);
    redirect_en = 1'b1; redirect_pc = 32'h104;
    step(); chk_req("rec", 1'b1, 32'h104);
    chk("rec.fault", {31'd0, fetch_fault}, 32'd0);
    redirect_en = 1'b0;
    step(); chk_hold("h104", 32'h104);

    // Misaligned redirect with a request outstanding: fault after ack.
    imem_ack = 1'b0; advance = 1'b1;
    step(); chk_req("r108", 1'b1, 32'h108);
    advance = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h3;
    step(); chk_req("pf", 1'b1, 32'h108);
    chk("pf.fault", {31'd0, fetch_fault}, 32'd1);
    redirect_en = 1'b0; imem_ack = 1'b1;
    step();
    chk("pf2.req", {31'd0, imem_req}, 32'd0);
    chk("pf2.fault", {31'd0, fetch_fault}, 32'd1);

    // PC wraps modulo 2^32.
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); chk_req("rtop", 1'b1, 32'hFFFF_FFFC);
    chk("rtop.fault", {31'd0, fetch_fault}, 32'd0);
    redirect_en = 1'b0;
    step(); chk_hold("htop", 32'hFFFF_FFFC);
    advance = 1'b1;
    step(); chk_req("wrap", 1'b1, 32'h0);
    advance = 1'b0; imem_ack = 1'b0;
    step(); chk_req("wrap2", 1'b1, 32'h0);

    // Reset mid-request; a late ack is ignored.
    rst = 1'b1;
    step(); chk_reset("mrst");
    imem_ack = 1'b1;
    step(); chk_reset("mrst2");
    rst = 1'b0;
    step(); chk_req("rest", 1'b1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
